// File: rtl/instr_issuer.sv
// ---------------------------------------------------------------------------
// instr_issuer
//   Fetches 9-bit instruction words from a synchronous ROM and presents them,
//   one at a time, to a simple processor.  mvi (opcode 001) carries a second
//   word, the immediate, fetched from the following ROM address.  A halt word
//   (opcode 111) parks the block in HALTED until reset.
//
// Ports
//   Clock     in   1  rising-edge clock
//   Reset     in   1  asynchronous, active-high reset
//   Enable    in   1  level; permits starting the next instruction
//   MemAddr   out  5  ROM word address (the program counter)
//   MemData   in   9  ROM read data, valid the cycle after MemAddr
//   DIN       out  9  word on the processor bus
//   Run       out  1  one-cycle start pulse for the word on DIN
//   Done      in   1  processor completion, looked at only while waiting
//   Halt      out  1  high while halted
//   Error     out  1  sticky completion-timeout flag
//   Count     out  8  retired instructions, saturating at 255
//   state_dbg out  3  current FSM state, for observation only
//
// Run/Done handshake: Run is high for exactly one cycle (ISSUE) and offers
// the instruction word on DIN.  From the next cycle DIN carries the immediate
// (mvi) or stays on the instruction, and is held until Done is sampled high.
// Done is meaningful only in the cycles after the Run pulse; a Done seen in
// any other cycle, including the Run cycle itself, has no effect.  If Done
// stays low for 15 waiting cycles the instruction is abandoned, Error is set
// and the block halts.
// ---------------------------------------------------------------------------
module instr_issuer (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Enable,
   output logic [4:0] MemAddr,
   input  logic [8:0] MemData,
   output logic [8:0] DIN,
   output logic       Run,
   input  logic       Done,
   output logic       Halt,
   output logic       Error,
   output logic [7:0] Count,
   output logic [2:0] state_dbg
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_LATCH     = 3'd2,
      ST_FETCH_IMM = 3'd3,
      ST_LATCH_IMM = 3'd4,
      ST_ISSUE     = 3'd5,
      ST_WAIT      = 3'd6,
      ST_HALTED    = 3'd7
   } state_t;

   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_HALT = 3'b111;
   // Watchdog value in the 15th waiting cycle; one more low Done is a timeout.
   localparam logic [3:0] WD_LAST = 4'd14;
   localparam logic [7:0] CNT_MAX = 8'd255;

   state_t     state;
   state_t     state_next;
   logic [4:0] pc;
   logic [8:0] ir;
   logic [8:0] imm;
   logic [3:0] wd;
   logic [7:0] count_q;
   logic       error_q;

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (Enable) state_next = ST_FETCH;
         end
         ST_FETCH: begin
            state_next = ST_LATCH;
         end
         ST_LATCH: begin
            // Decode straight from the ROM word being latched this cycle.
            if (MemData[2:0] == OP_HALT)     state_next = ST_HALTED;
            else if (MemData[2:0] == OP_MVI) state_next = ST_FETCH_IMM;
            else                             state_next = ST_ISSUE;
         end
         ST_FETCH_IMM: begin
            state_next = ST_LATCH_IMM;
         end
         ST_LATCH_IMM: begin
            state_next = ST_ISSUE;
         end
         ST_ISSUE: begin
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (Done)               state_next = Enable ? ST_FETCH : ST_IDLE;
            else if (wd == WD_LAST) state_next = ST_HALTED;
         end
         ST_HALTED: begin
            state_next = ST_HALTED;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Outputs (all derived from registers, so reset reaches them immediately)
   // -------------------------------------------------------------------------
   always_comb begin
      MemAddr   = pc;
      Run       = 1'b0;
      Halt      = 1'b0;
      DIN       = ir;
      Error     = error_q;
      Count     = count_q;
      state_dbg = state;
      if (state == ST_ISSUE)  Run  = 1'b1;
      if (state == ST_HALTED) Halt = 1'b1;
      // After the Run cycle an mvi hands the processor its immediate.
      if ((state == ST_WAIT) && (ir[2:0] == OP_MVI)) DIN = imm;
   end

   // -------------------------------------------------------------------------
   // State and datapath registers
   // -------------------------------------------------------------------------
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state   <= ST_IDLE;
         pc      <= 5'd0;
         ir      <= 9'd0;
         imm     <= 9'd0;
         wd      <= 4'd0;
         count_q <= 8'd0;
         error_q <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            ST_LATCH: begin
               ir <= MemData;
               pc <= pc + 5'd1;          // 5-bit PC wraps 31 -> 0
            end
            ST_LATCH_IMM: begin
               imm <= MemData;
               pc  <= pc + 5'd1;
            end
            ST_ISSUE: begin
               wd <= 4'd0;
            end
            ST_WAIT: begin
               if (Done) begin
                  if (count_q != CNT_MAX) count_q <= count_q + 8'd1;
               end else begin
                  wd <= wd + 4'd1;
                  if (wd == WD_LAST) error_q <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_issuer.sv
// ---------------------------------------------------------------------------
// tb_instr_issuer
//   Directed bench for instr_issuer.  For each scenario the bench fills a ROM,
//   an Enable schedule and a list of Done delays (cycles from Run to Done, 0 =
//   never), then a behavioural model walks the program instruction by
//   instruction and writes the expected outputs for every cycle after reset
//   release, plus the Done schedule that drives the DUT.  One compare process
//   checks every cycle; literal end-of-scenario values pin the model.
// ---------------------------------------------------------------------------
module tb_instr_issuer;

   localparam int MAXC = 2048;

   // ---------------- clock / reset / DUT ----------------
   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       Enable = 1'b0;
   logic       Done = 1'b0;
   logic [8:0] MemData;
   logic [4:0] MemAddr;
   logic [8:0] DIN;
   logic       Run;
   logic       Halt;
   logic       Error;
   logic [7:0] Count;
   logic [2:0] state_dbg;

   always #5 Clock = ~Clock;

   instr_issuer dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .Enable   (Enable),
      .MemAddr  (MemAddr),
      .MemData  (MemData),
      .DIN      (DIN),
      .Run      (Run),
      .Done     (Done),
      .Halt     (Halt),
      .Error    (Error),
      .Count    (Count),
      .state_dbg(state_dbg)
   );

   // Synchronous ROM: data for an address appears the following cycle.
   logic [8:0] rom [32];
   always @(posedge Clock) MemData <= rom[MemAddr];

   // ---------------- scenario inputs and model outputs ----------------
   bit         en_s     [MAXC];
   bit         done_s   [MAXC];
   bit         exp_run  [MAXC];
   logic [8:0] exp_din  [MAXC];
   logic [4:0] exp_addr [MAXC];
   bit         exp_halt [MAXC];
   bit         exp_err  [MAXC];
   logic [7:0] exp_cnt  [MAXC];
   int         dly_q [$];
   bit         done_in_issue;
   logic [8:0] exp_q [$];         // words expected on DIN at each Run pulse

   int    total = 0;
   int    bad = 0;
   bit    checking = 0;
   int    cyc = 0;
   string tname = "";

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   function automatic void put(int c, bit run, logic [8:0] din, int pc, bit halt, bit err, int cnt);
      if (c < MAXC) begin
         exp_run[c]  = run;
         exp_din[c]  = din;
         exp_addr[c] = pc[4:0];
         exp_halt[c] = halt;
         exp_err[c]  = err;
         exp_cnt[c]  = cnt[7:0];
      end
   endfunction

   // Walks the program one instruction at a time using the issue timing
   // rules: fetch+latch (2 cycles), imm fetch+latch (2 more for mvi), one Run
   // cycle, then waiting until Done or 15 waiting cycles without it.
   task automatic build_model(input int n);
      int         c;
      int         r;
      int         d;
      int         pc;
      int         cnt;
      bit         err;
      bit         go;
      bit         mvi;
      logic [8:0] ir;
      logic [8:0] imm;
      logic [8:0] w;
      logic [8:0] wdin;
      pc = 0; cnt = 0; err = 0; go = 0; ir = 9'd0; imm = 9'd0; c = 0;
      for (int i = 0; i < MAXC; i++) begin
         done_s[i] = 0;
         put(i, 0, 9'd0, 0, 0, 0, 0);
      end
      exp_q.delete();
      while (c < n) begin
         if (!go) begin
            while (c < n && !en_s[c]) begin
               put(c, 0, ir, pc, 0, err, cnt);
               c++;
            end
            if (c >= n) break;
            put(c, 0, ir, pc, 0, err, cnt);   // idle cycle in which Enable is seen
            c++;
         end
         put(c, 0, ir, pc, 0, err, cnt);
         put(c + 1, 0, ir, pc, 0, err, cnt);
         w  = rom[pc[4:0]];
         ir = w;
         pc = (pc + 1) % 32;
         c  = c + 2;
         if (w[2:0] == 3'b111) begin
            while (c < n) begin
               put(c, 0, ir, pc, 1, err, cnt);
               c++;
            end
            break;
         end
         mvi = (w[2:0] == 3'b001);
         if (mvi) begin
            put(c, 0, ir, pc, 0, err, cnt);
            put(c + 1, 0, ir, pc, 0, err, cnt);
            imm = rom[pc[4:0]];
            pc  = (pc + 1) % 32;
            c   = c + 2;
         end
         r = c;
         put(r, 1, ir, pc, 0, err, cnt);
         if (r < n) exp_q.push_back(ir);
         if (done_in_issue && r < MAXC) done_s[r] = 1;
         d = (dly_q.size() > 0) ? dly_q.pop_front() : 1;
         wdin = mvi ? imm : ir;
         if (d >= 1 && r + d < MAXC) done_s[r + d] = 1;
         if (d >= 1 && d <= 15) begin
            for (int k = 1; k <= d; k++) put(r + k, 0, wdin, pc, 0, err, cnt);
            if (cnt < 255) cnt++;
            go = (r + d < MAXC) ? en_s[r + d] : 1'b0;
            c  = r + d + 1;
         end else begin
            for (int k = 1; k <= 15; k++) put(r + k, 0, wdin, pc, 0, err, cnt);
            err = 1;
            c   = r + 16;
            while (c < n) begin
               put(c, 0, ir, pc, 1, err, cnt);
               c++;
            end
            break;
         end
      end
   endtask

   // ---------------- compare process ----------------
   always @(negedge Clock) begin
      if (checking) begin
         check($sformatf("%s c%0d Run", tname, cyc), 32'(Run), 32'(exp_run[cyc]));
         check($sformatf("%s c%0d DIN", tname, cyc), 32'(DIN), 32'(exp_din[cyc]));
         check($sformatf("%s c%0d MemAddr", tname, cyc), 32'(MemAddr), 32'(exp_addr[cyc]));
         check($sformatf("%s c%0d Halt", tname, cyc), 32'(Halt), 32'(exp_halt[cyc]));
         check($sformatf("%s c%0d Error", tname, cyc), 32'(Error), 32'(exp_err[cyc]));
         check($sformatf("%s c%0d Count", tname, cyc), 32'(Count), 32'(exp_cnt[cyc]));
         if (Run === 1'b1) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL %s c%0d issue: got Run with DIN=%0h, want no issue", tname, cyc, DIN);
            end else begin
               check($sformatf("%s c%0d issued word", tname, cyc), 32'(DIN), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clear_setup();
      for (int i = 0; i < 32; i++) rom[i] = 9'd0;
      for (int i = 0; i < MAXC; i++) en_s[i] = 0;
      dly_q.delete();
      done_in_issue = 0;
   endtask

   task automatic en_range(input int from, input int to);
      for (int i = from; i <= to && i < MAXC; i++) en_s[i] = 1;
   endtask

   task automatic run_test(input int n);
      Reset = 1; Enable = 0; Done = 0; checking = 0;
      repeat (2) @(posedge Clock);
      #1;
      build_model(n);
      Reset = 0;
      for (int c = 0; c < n; c++) begin
         cyc = c;
         Enable = en_s[c];
         Done = done_s[c];
         checking = 1;
         @(posedge Clock);
         #1;
      end
      checking = 0;
      Enable = 0;
      Done = 0;
      check({tname, " issues left"}, 32'(exp_q.size()), 32'd0);
   endtask

   function automatic logic [2:0] pick_op(int i);
      case (i % 6)
         0:       return 3'b000;
         1:       return 3'b010;
         2:       return 3'b011;
         3:       return 3'b100;
         4:       return 3'b101;
         default: return 3'b110;
      endcase
   endfunction

   // ---------------- scenarios ----------------
   initial begin
      clear_setup();
      #1;
      check("reset Run", 32'(Run), 32'd0);
      check("reset DIN", 32'(DIN), 32'd0);
      check("reset MemAddr", 32'(MemAddr), 32'd0);
      check("reset Count", 32'(Count), 32'd0);

      // mv R1,R2, Enable for one cycle only, Done 2 cycles after Run
      tname = "mv";
      clear_setup();
      rom[0] = 9'b010001000;
      en_s[0] = 1;
      dly_q.push_back(2);
      run_test(12);
      check("mv model run@3", 32'(exp_run[3]), 32'd1);
      check("mv model din@5", 32'(exp_din[5]), 32'h088);
      check("mv end Count", 32'(Count), 32'd1);
      check("mv end MemAddr", 32'(MemAddr), 32'd1);
      check("mv end DIN", 32'(DIN), 32'h088);

      // mvi R3 with immediate 0x05A
      tname = "mvi";
      clear_setup();
      rom[0] = 9'b000011001;
      rom[1] = 9'h05A;
      en_s[0] = 1;
      dly_q.push_back(3);
      run_test(14);
      check("mvi model din@5", 32'(exp_din[5]), 32'h019);
      check("mvi model din@6", 32'(exp_din[6]), 32'h05A);
      check("mvi end MemAddr", 32'(MemAddr), 32'd2);
      check("mvi end Count", 32'(Count), 32'd1);

      // add, sub, halt
      tname = "add_sub_halt";
      clear_setup();
      rom[0] = 9'h0D2;
      rom[1] = 9'h053;
      rom[2] = 9'h007;
      en_range(0, MAXC - 1);
      dly_q.push_back(3);
      dly_q.push_back(3);
      run_test(22);
      check("ash end Count", 32'(Count), 32'd2);
      check("ash end Halt", 32'(Halt), 32'd1);
      check("ash end MemAddr", 32'(MemAddr), 32'd3);
      check("ash end Error", 32'(Error), 32'd0);

      // late Enable, Done pulse in the Run cycle, then no Done: timeout
      tname = "timeout";
      clear_setup();
      rom[0] = 9'h088;
      en_range(4, MAXC - 1);
      done_in_issue = 1;
      dly_q.push_back(0);
      run_test(28);
      check("to model err@22", 32'(exp_err[22]), 32'd0);
      check("to model err@23", 32'(exp_err[23]), 32'd1);
      check("to end Error", 32'(Error), 32'd1);
      check("to end Halt", 32'(Halt), 32'd1);
      check("to end Count", 32'(Count), 32'd0);

      // Done in the 15th waiting cycle still retires
      tname = "done_at_15";
      clear_setup();
      rom[0] = 9'h088;
      en_s[0] = 1;
      dly_q.push_back(15);
      run_test(24);
      check("d15 end Error", 32'(Error), 32'd0);
      check("d15 end Count", 32'(Count), 32'd1);

      // Done one cycle too late
      tname = "done_at_16";
      clear_setup();
      rom[0] = 9'h088;
      en_s[0] = 1;
      dly_q.push_back(16);
      run_test(24);
      check("d16 end Error", 32'(Error), 32'd1);
      check("d16 end Count", 32'(Count), 32'd0);

      // 31 one-word instructions, mvi at 31, immediate wraps to address 0
      tname = "pc_wrap";
      clear_setup();
      rom[0] = 9'h088;
      for (int i = 1; i < 31; i++) rom[i] = {3'(i % 8), 3'((i + 3) % 8), pick_op(i)};
      rom[31] = 9'h019;
      en_range(0, 128);
      run_test(136);
      check("wrap end MemAddr", 32'(MemAddr), 32'd1);
      check("wrap end Count", 32'(Count), 32'd32);
      check("wrap end DIN", 32'(DIN), 32'h019);

      // Reset asserted while waiting on the second instruction
      tname = "reset_wait";
      clear_setup();
      rom[0] = 9'h088;
      rom[1] = 9'h0D2;
      en_range(0, MAXC - 1);
      dly_q.push_back(2);
      dly_q.push_back(20);
      run_test(11);
      check("rw pre Count", 32'(Count), 32'd1);
      check("rw pre MemAddr", 32'(MemAddr), 32'd2);
      Reset = 1;
      #1;
      check("rw Run", 32'(Run), 32'd0);
      check("rw DIN", 32'(DIN), 32'd0);
      check("rw MemAddr", 32'(MemAddr), 32'd0);
      check("rw Count", 32'(Count), 32'd0);
      check("rw Error", 32'(Error), 32'd0);
      check("rw Halt", 32'(Halt), 32'd0);

      tname = "restart";
      for (int i = 0; i < MAXC; i++) en_s[i] = 0;
      en_s[0] = 1;
      dly_q.delete();
      dly_q.push_back(2);
      run_test(10);
      check("rs end MemAddr", 32'(MemAddr), 32'd1);
      check("rs end Count", 32'(Count), 32'd1);

      // Long stream of one-word instructions: Count saturates
      tname = "saturate";
      clear_setup();
      for (int i = 0; i < 32; i++) rom[i] = 9'h088;
      en_range(0, MAXC - 1);
      run_test(1040);
      check("sat end Count", 32'(Count), 32'd255);
      check("sat end Error", 32'(Error), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_issuer.md
INSTR_ISSUER -- requirements
Module: instr_issuer

Interface
REQ-001 Clock  input  1  single clock, all state updates on rising edge.
REQ-002 Reset  input  1  asynchronous, active-high reset; all state cleared while high.
REQ-003 Enable  input  1  level; high permits issuing instructions from ROM.
REQ-004 MemAddr  output  5  ROM word address, equal to internal program counter PC.
REQ-005 MemData  input  9  ROM read data, valid one cycle after MemAddr (synchronous ROM).
REQ-006 DIN  output  9  word driven to processor bus: instruction, then immediate for mvi.
REQ-007 Run  output  1  one-cycle pulse starting processor execution of the word on DIN.
REQ-008 Done  input  1  processor completion; sampled only in WAIT.
REQ-009 Halt  output  1  high while in HALTED.
REQ-010 Error  output  1  sticky flag, set on Done timeout.
REQ-011 Count  output  8  number of retired instructions.

Function
REQ-012 Word format: opcode [2:0], Rx [5:3], Ry [8:6]; opcodes mv=000, mvi=001, add=010, sub=011, halt=111; 100-110 issued as one-word instructions.
REQ-013 States: IDLE, FETCH, LATCH, FETCH_IMM, LATCH_IMM, ISSUE, WAIT, HALTED.
REQ-014 IDLE: Run=0; Enable=1 -> FETCH next edge, else stay.
REQ-015 FETCH: MemAddr=PC; -> LATCH.
REQ-016 LATCH: IR<=MemData, PC<=PC+1; opcode 111 -> HALTED, 001 -> FETCH_IMM, else -> ISSUE.
REQ-017 FETCH_IMM: MemAddr=PC (immediate address); -> LATCH_IMM.
REQ-018 LATCH_IMM: IMM<=MemData, PC<=PC+1; -> ISSUE.
REQ-019 ISSUE: Run=1 for exactly this cycle, DIN=IR; watchdog cleared to 0; -> WAIT.
REQ-020 WAIT: DIN=IMM if opcode 001, else DIN=IR; DIN held stable until Done sampled.
REQ-021 WAIT, Done=1: Count<=Count+1 (saturates at 255); Enable=1 -> FETCH, Enable=0 -> IDLE.
REQ-022 WAIT, Done=0: 4-bit watchdog increments; reaching 15 with no Done -> Error<=1, -> HALTED.
REQ-023 Done high outside WAIT (including ISSUE cycle) is ignored.
REQ-024 Enable deassertion mid-instruction does not abort; current instruction completes, then IDLE.
REQ-025 PC is 5 bits and wraps 31 -> 0 on increment; applies to both instruction and immediate fetch.
REQ-026 HALTED: terminal; Run=0, Halt=1; left only via Reset.
REQ-027 Outside ISSUE/WAIT, DIN = IR (last latched word); Run never asserted outside ISSUE.
REQ-028 Issue latency: Enable rising in IDLE -> Run pulse 3 cycles later (one-word) or 5 cycles later (mvi).

Reset
REQ-029 Reset high: state=IDLE, PC=0, IR=0, IMM=0, watchdog=0, Count=0, Error=0, Halt=0, Run=0, DIN=0, MemAddr=0, asynchronously and independent of Clock.
REQ-030 Reset asserted in any state, including WAIT with Run just pulsed, aborts the instruction without incrementing Count.
REQ-031 After Reset release, no Run until Enable sampled high in IDLE.

Verification
REQ-032 ROM[0]=mv R1,R2 (9'b010001000), Done 2 cycles after Run -> one Run pulse, DIN=9'h088 held through Done, Count=1, MemAddr=1.
REQ-033 ROM[0]=mvi R3 (9'b000011001), ROM[1]=9'h05A -> Run with DIN=9'h019, next cycle DIN=9'h05A held until Done, PC=2 afterwards.
REQ-034 ROM[0]=add, ROM[1]=sub, ROM[2]=halt (opcode 111), Done 3 cycles after each Run -> exactly two Run pulses, Count=2, Halt=1, PC=3.
REQ-035 Done held low 15 cycles after Run -> Error=1, Halt=1, Count unchanged; Done pulse in ISSUE cycle ignored.
REQ-036 PC preset to 31 via sequence of 31 one-word instructions, ROM[31]=mvi, ROM[0]=immediate -> immediate read from address 0, PC=1.
REQ-037 Reset pulsed during WAIT -> all outputs at reset values same cycle; Enable=1 after release restarts from address 0.
